// File: rtl/vpifo_port_arbiter.sv
// rtl/vpifo_port_arbiter.sv - round-robin sharing of the vPIFO push/pop port with retry and pop-return routing
// Optional statistics counters are built when VPIFO_ARB_STAT_EN is defined.
module vpifo_port_arbiter #(
   parameter int PTW       = 16,
   parameter int MTW       = 0,
   parameter int TREE_NUM  = 4,
   parameter int REQ_NUM   = 4,
   parameter int POP_LAT   = 2,
   parameter int BACKOFF   = 3,
   parameter int RETRY_MAX = 4,
   localparam int DW  = MTW + PTW,
   localparam int TNB = (TREE_NUM > 1) ? $clog2(TREE_NUM) : 1,
   localparam int RNB = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [REQ_NUM-1:0]     i_req_valid,
   input  logic [REQ_NUM-1:0]     i_req_op,
   input  logic [REQ_NUM*TNB-1:0] i_req_tree_id,
   input  logic [REQ_NUM*DW-1:0]  i_req_data,
   output logic [REQ_NUM-1:0]     o_req_ready,
   output logic [REQ_NUM-1:0]     o_rsp_valid,
   output logic                   o_rsp_fail,
   output logic [DW-1:0]          o_rsp_data,
   output logic [TNB-1:0]         o_tree_id,
   output logic                   o_push,
   output logic [DW-1:0]          o_push_data,
   output logic                   o_pop,
   input  logic                   i_task_fail,
   input  logic [DW-1:0]          i_pop_data
`ifdef VPIFO_ARB_STAT_EN
   ,
   output logic [31:0]            o_stat_push,
   output logic [31:0]            o_stat_pop,
   output logic [31:0]            o_stat_retry,
   output logic [31:0]            o_stat_drop
`endif
);

   localparam int CNB = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
   localparam int BKB = $clog2(BACKOFF + 1);
   localparam logic [CNB-1:0] RMAX    = CNB'(RETRY_MAX);
   localparam logic [BKB-1:0] BK_LOAD = BKB'(BACKOFF);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_BACKOFF
   } state_t;

   state_t             state;
   state_t             state_nxt;

   logic               iss_op;
   logic [TNB-1:0]     iss_tree;
   logic [DW-1:0]      iss_data;
   logic [RNB-1:0]     iss_owner;
   logic [RNB-1:0]     rr_ptr;
   logic [CNB-1:0]     retry_cnt;
   logic [BKB-1:0]     bk_timer;

   logic [POP_LAT-1:0] tag_v;
   logic [RNB-1:0]     tag_own [POP_LAT];

   logic               skid_v;
   logic               skid_fail;
   logic [RNB-1:0]     skid_own;

   logic               pick_found;
   logic [RNB-1:0]     pick_idx;
   logic [RNB-1:0]     cand;
   logic               grant_open;
   logic               ok_done;
   logic               drop_done;
   logic               start_bk;
   logic               new_rsp;
   logic               pop_ret;
   logic               hs;

   function automatic logic [RNB-1:0] rr_slot(input logic [RNB-1:0] base, input int k);
      int s;
      s = (int'(base) + k) % REQ_NUM;
      return RNB'(s);
   endfunction

   function automatic logic [REQ_NUM-1:0] onehot(input logic [RNB-1:0] idx);
      logic [REQ_NUM-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int k = 0; k < REQ_NUM; k++) begin
         cand = rr_slot(rr_ptr, k);
         if (!pick_found && i_req_valid[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   assign pop_ret = tag_v[POP_LAT-1];

   always_comb begin
      state_nxt  = state;
      grant_open = 1'b0;
      ok_done    = 1'b0;
      drop_done  = 1'b0;
      start_bk   = 1'b0;
      new_rsp    = 1'b0;
      hs         = 1'b0;
      case (state)
         ST_IDLE: grant_open = 1'b1;
         ST_ISSUE: begin
            if (!i_task_fail) begin
               ok_done    = 1'b1;
               grant_open = 1'b1;
            end else if (retry_cnt < RMAX) begin
               start_bk  = 1'b1;
               state_nxt = ST_BACKOFF;
            end else begin
               drop_done  = 1'b1;
               grant_open = 1'b1;
            end
         end
         ST_BACKOFF: begin
            if (bk_timer == BKB'(1)) state_nxt = ST_ISSUE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      new_rsp = (ok_done && !iss_op) || drop_done;
      // A colliding completion is about to occupy the skid, so hold grants off from this cycle on.
      hs = grant_open && pick_found && !skid_v && !(pop_ret && new_rsp) && !i_rst;
      if (grant_open) state_nxt = hs ? ST_ISSUE : ST_IDLE;
   end

   assign o_req_ready = hs ? onehot(pick_idx) : '0;
   assign o_push      = (state == ST_ISSUE) && !iss_op;
   assign o_pop       = (state == ST_ISSUE) && iss_op;
   assign o_tree_id   = (state == ST_ISSUE) ? iss_tree : '0;
   assign o_push_data = o_push ? iss_data : '0;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= ST_IDLE;
         iss_op      <= 1'b0;
         iss_tree    <= '0;
         iss_data    <= '0;
         iss_owner   <= '0;
         rr_ptr      <= '0;
         retry_cnt   <= '0;
         bk_timer    <= '0;
         tag_v       <= '0;
         for (int i = 0; i < POP_LAT; i++) tag_own[i] <= '0;
         skid_v      <= 1'b0;
         skid_fail   <= 1'b0;
         skid_own    <= '0;
         o_rsp_valid <= '0;
         o_rsp_fail  <= 1'b0;
         o_rsp_data  <= '0;
      end else begin
         state <= state_nxt;

         if (hs) begin
            iss_op    <= i_req_op[pick_idx];
            iss_tree  <= i_req_tree_id[int'(pick_idx)*TNB +: TNB];
            iss_data  <= i_req_data[int'(pick_idx)*DW +: DW];
            iss_owner <= pick_idx;
            rr_ptr    <= (pick_idx == RNB'(REQ_NUM - 1)) ? '0 : pick_idx + 1'b1;
         end

         if (ok_done || drop_done) retry_cnt <= '0;
         else if (start_bk)        retry_cnt <= retry_cnt + 1'b1;

         if (start_bk)                  bk_timer <= BK_LOAD;
         else if (state == ST_BACKOFF)  bk_timer <= bk_timer - 1'b1;

         // The tag pipe tracks which requester owns each pop still in the tree's read latency.
         tag_v[0]   <= ok_done && iss_op;
         tag_own[0] <= iss_owner;
         for (int i = 1; i < POP_LAT; i++) begin
            tag_v[i]   <= tag_v[i-1];
            tag_own[i] <= tag_own[i-1];
         end

         if (pop_ret) begin
            o_rsp_valid <= onehot(tag_own[POP_LAT-1]);
            o_rsp_fail  <= 1'b0;
            o_rsp_data  <= i_pop_data;
         end else if (skid_v) begin
            o_rsp_valid <= onehot(skid_own);
            o_rsp_fail  <= skid_fail;
         end else if (new_rsp) begin
            o_rsp_valid <= onehot(iss_owner);
            o_rsp_fail  <= drop_done;
         end else begin
            o_rsp_valid <= '0;
            o_rsp_fail  <= 1'b0;
         end

         if (pop_ret && new_rsp) begin
            skid_v    <= 1'b1;
            skid_fail <= drop_done;
            skid_own  <= iss_owner;
         end else if (!pop_ret) begin
            skid_v    <= 1'b0;
         end
      end
   end

`ifdef VPIFO_ARB_STAT_EN
   logic [31:0] stat_push;
   logic [31:0] stat_pop;
   logic [31:0] stat_retry;
   logic [31:0] stat_drop;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         stat_push  <= '0;
         stat_pop   <= '0;
         stat_retry <= '0;
         stat_drop  <= '0;
      end else begin
         if (ok_done && !iss_op) stat_push <= sat_inc(stat_push);
         if (ok_done && iss_op)  stat_pop  <= sat_inc(stat_pop);
         if (state == ST_BACKOFF && state_nxt == ST_ISSUE) stat_retry <= sat_inc(stat_retry);
         if (drop_done)          stat_drop <= sat_inc(stat_drop);
      end
   end

   assign o_stat_push  = stat_push;
   assign o_stat_pop   = stat_pop;
   assign o_stat_retry = stat_retry;
   assign o_stat_drop  = stat_drop;
`endif

endmodule
